led_trail_pwm: RTL and testbench

Downstream stage of the bouncing-LED block. Takes the 10-bit one-hot pattern that block drives and renders it on the physical LEDs with a fading "comet tail". Each LED jumps to full brightness while its pattern bit is set, then decays stepwise to off. Brightness is produced by a shared PWM counter compared against a per-LED intensity level.

---
 rtl/led_pkg.sv | 21 ++
 rtl/led_pwm_channel.sv | 63 ++++++
 rtl/led_trail_pwm.sv | 90 +++++++++
 tb/tb_led_trail_pwm.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared constants and types for the LED comet-trail renderer.
package led_pkg;

    localparam int N_LEDS        = 10;
    localparam int LVL_W         = 4;
    localparam int LVL_MAX       = (1 << LVL_W) - 1;
    localparam int PWM_DIV_DEF   = 64;
    localparam int DECAY_DIV_DEF = 2_500_000;

    typedef logic [LVL_W-1:0] level_t;

    // Width of a counter that must hold 0..div-1; never narrower than one bit.
    function automatic int cnt_width(input int div);
        if (div > 1) begin
            return $clog2(div);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: intensity level with load/decay, and the PWM output flop.
module led_pwm_channel
    import led_pkg::*;
#(
    parameter int LVL_W = led_pkg::LVL_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             set_i,
    input  logic             decay_tick_i,
    input  logic [LVL_W-1:0] pwm_cnt_i,
    input  logic             trail_en_i,
    input  logic             raw_i,
    output logic             led_o
);

    localparam logic [LVL_W-1:0] LEVEL_FULL = '1;

    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    logic             led_q;
    logic             led_d;

    // Next level: a set pattern bit reloads full brightness and beats a decay step.
    always_comb begin
        level_d = level_q;
        if (set_i) begin
            level_d = LEVEL_FULL;
        end else if (decay_tick_i) begin
            if (level_q != '0) begin
                level_d = level_q - LVL_W'(1);
            end else begin
                level_d = level_q;
            end
        end else begin
            level_d = level_q;
        end
    end

    // Next LED drive: PWM compare in trail mode, raw pattern bit in bypass.
    always_comb begin
        led_d = 1'b0;
        if (trail_en_i) begin
            led_d = (level_q > pwm_cnt_i);
        end else begin
            led_d = raw_i;
        end
    end

    // Level and output registers; reset clears any tail immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            level_q <= '0;
            led_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            led_q   <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/led_trail_pwm.sv
// Comet-trail LED renderer: shared decay/PWM timebase feeding per-LED channels.
module led_trail_pwm
    import led_pkg::*;
#(
    parameter int N_LEDS    = led_pkg::N_LEDS,
    parameter int LVL_W     = led_pkg::LVL_W,
    parameter int PWM_DIV   = led_pkg::PWM_DIV_DEF,
    parameter int DECAY_DIV = led_pkg::DECAY_DIV_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N_LEDS-1:0] pattern_i,
    input  logic              trail_en_i,
    output logic [N_LEDS-1:0] led_o
);

    localparam int DCNT_W = cnt_width(DECAY_DIV);
    localparam int PCNT_W = cnt_width(PWM_DIV);

    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECAY_DIV - 1);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PWM_DIV - 1);
    // PWM frame has LVL_MAX slots, so the slot counter stops one short of all-ones.
    localparam logic [LVL_W-1:0]  PWM_LAST  = LVL_W'((1 << LVL_W) - 2);

    logic [DCNT_W-1:0] dcnt_q;
    logic [DCNT_W-1:0] dcnt_d;
    logic [PCNT_W-1:0] pcnt_q;
    logic [PCNT_W-1:0] pcnt_d;
    logic [LVL_W-1:0]  pwm_cnt_q;
    logic [LVL_W-1:0]  pwm_cnt_d;
    logic              decay_tick_s;
    logic              pwm_wrap_s;

    assign decay_tick_s = (dcnt_q == DCNT_LAST);
    assign pwm_wrap_s   = (pcnt_q == PCNT_LAST);

    // Next-state for the decay prescaler, PWM prescaler and PWM slot counter.
    always_comb begin
        dcnt_d    = dcnt_q;
        pcnt_d    = pcnt_q;
        pwm_cnt_d = pwm_cnt_q;

        if (decay_tick_s) begin
            dcnt_d = '0;
        end else begin
            dcnt_d = dcnt_q + DCNT_W'(1);
        end

        if (pwm_wrap_s) begin
            pcnt_d = '0;
            if (pwm_cnt_q == PWM_LAST) begin
                pwm_cnt_d = '0;
            end else begin
                pwm_cnt_d = pwm_cnt_q + LVL_W'(1);
            end
        end else begin
            pcnt_d    = pcnt_q + PCNT_W'(1);
            pwm_cnt_d = pwm_cnt_q;
        end
    end

    // Timebase registers; they keep running in bypass so trail mode resumes in phase.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dcnt_q    <= '0;
            pcnt_q    <= '0;
            pwm_cnt_q <= '0;
        end else begin
            dcnt_q    <= dcnt_d;
            pcnt_q    <= pcnt_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    for (genvar k = 0; k < N_LEDS; k++) begin : g_ch
        led_pwm_channel #(
            .LVL_W (LVL_W)
        ) u_ch (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .set_i        (pattern_i[k]),
            .decay_tick_i (decay_tick_s),
            .pwm_cnt_i    (pwm_cnt_q),
            .trail_en_i   (trail_en_i),
            .raw_i        (pattern_i[k]),
            .led_o        (led_o[k])
        );
    end

endmodule

// File: tb/tb_led_trail_pwm.sv
// Directed bench for led_trail_pwm (PWM_DIV=1; DECAY_DIV=4, plus a DECAY_DIV=20 copy for duty).
module tb_led_trail_pwm;

    logic       clk = 1'b0;
    logic       rst;
    logic       trail_en;
    logic [9:0] pattern;
    logic [9:0] pattern2;
    logic [9:0] led;
    logic [9:0] led2;
    int         checks = 0;
    int         errors = 0;
    int         tcount;
    logic [3:0] lvl [10];

    always #5 clk = ~clk;

    // Cycles since reset release; gives the expected decay / PWM phase.
    always @(posedge clk or posedge rst) begin
        if (rst) tcount <= 0;
        else     tcount <= tcount + 1;
    end

    led_trail_pwm #(.N_LEDS(10), .LVL_W(4), .PWM_DIV(1), .DECAY_DIV(4)) dut (
        .clk_i(clk), .rst_i(rst), .pattern_i(pattern), .trail_en_i(trail_en), .led_o(led));

    led_trail_pwm #(.N_LEDS(10), .LVL_W(4), .PWM_DIV(1), .DECAY_DIV(20)) dut2 (
        .clk_i(clk), .rst_i(rst), .pattern_i(pattern2), .trail_en_i(trail_en), .led_o(led2));

    for (genvar g = 0; g < 10; g++) begin : g_tap
        assign lvl[g] = dut.g_ch[g].u_ch.level_q;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(input int m, input int v);
        int n = 0;
        while (((tcount % m) != v) && (n < 100)) begin
            step();
            n++;
        end
        checks++;
        if ((tcount % m) != v) begin
            errors++;
            $display("FAIL wait_phase: phase %0d expected %0d (timeout)", tcount % m, v);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            pattern = (i % 2 == 0) ? 10'h3FF : 10'h155;
            step();
            checks++;
            if (led !== 10'h000) begin
                errors++;
                $display("FAIL reset_led: got %h expected 000", led);
            end
            for (int k = 0; k < 10; k++) begin
                checks++;
                if (lvl[k] !== 4'd0) begin
                    errors++;
                    $display("FAIL reset_level[%0d]: got %0d expected 0", k, lvl[k]);
                end
            end
        end
        pattern = 10'h000;
        rst = 1'b0;
        checks++;
        if (dut.dcnt_q !== 2'd0 || dut.pwm_cnt_q !== 4'd0) begin
            errors++;
            $display("FAIL release_cnt0: dcnt %0d pwm %0d expected 0 0", dut.dcnt_q, dut.pwm_cnt_q);
        end
        step();
        checks++;
        if (dut.dcnt_q !== 2'd1 || dut.pwm_cnt_q !== 4'd1) begin
            errors++;
            $display("FAIL release_cnt1: dcnt %0d pwm %0d expected 1 1", dut.dcnt_q, dut.pwm_cnt_q);
        end
    endtask

    task automatic test_set_fade();
        int exp_lvl;
        wait_phase(4, 0);
        pattern = 10'h001;
        step();
        pattern = 10'h000;
        checks++;
        if (lvl[0] !== 4'd15 || led[0] !== 1'b0) begin
            errors++;
            $display("FAIL set_load: level %0d led %b expected 15 0", lvl[0], led[0]);
        end
        for (int n = 1; n <= 70; n++) begin
            step();
            if (n < 3) exp_lvl = 15;
            else       exp_lvl = 14 - (n - 3) / 4;
            if (exp_lvl < 0) exp_lvl = 0;
            checks++;
            if (lvl[0] !== 4'(exp_lvl)) begin
                errors++;
                $display("FAIL fade_level n=%0d: got %0d expected %0d", n, lvl[0], exp_lvl);
            end
            if (n == 1) begin
                checks++;
                if (led[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL rise_latency: got %b expected 1", led[0]);
                end
            end
            if (n >= 60) begin
                checks++;
                if (led[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL dark_at_zero n=%0d: got %b expected 0", n, led[0]);
                end
            end
        end
    endtask

    task automatic test_duty();
        int t0;
        int ones = 0;
        int n = 0;
        logic exp_led;
        wait_phase(20, 0);
        t0 = tcount;
        pattern2 = 10'h001;
        step();
        pattern2 = 10'h000;
        while ((tcount < t0 + 201) && (n < 400)) begin
            step();
            n++;
        end
        checks++;
        if (dut2.g_ch[0].u_ch.level_q !== 4'd5) begin
            errors++;
            $display("FAIL duty_level: got %0d expected 5", dut2.g_ch[0].u_ch.level_q);
        end
        for (int i = 0; i < 15; i++) begin
            exp_led = (((tcount - 1) % 15) < 5);
            checks++;
            if (led2[0] !== exp_led) begin
                errors++;
                $display("FAIL duty_slot %0d: got %b expected %b", (tcount - 1) % 15, led2[0], exp_led);
            end
            if (led2[0] === 1'b1) ones++;
            if (i < 14) step();
        end
        checks++;
        if (ones != 5) begin
            errors++;
            $display("FAIL duty_count: got %0d expected 5", ones);
        end
    endtask

    task automatic test_collision();
        wait_phase(4, 1);
        pattern = 10'h008;
        step();
        pattern = 10'h000;
        step();
        checks++;
        if (lvl[3] !== 4'd15) begin
            errors++;
            $display("FAIL collide_pre: got %0d expected 15", lvl[3]);
        end
        pattern = 10'h008;
        step();
        pattern = 10'h000;
        checks++;
        if (lvl[3] !== 4'd15) begin
            errors++;
            $display("FAIL collide_load: got %0d expected 15", lvl[3]);
        end
        step();
        step();
        step();
        checks++;
        if (lvl[3] !== 4'd15) begin
            errors++;
            $display("FAIL collide_hold: got %0d expected 15", lvl[3]);
        end
        step();
        checks++;
        if (lvl[3] !== 4'd14) begin
            errors++;
            $display("FAIL collide_decay: got %0d expected 14", lvl[3]);
        end
    endtask

    task automatic test_bounce_sweep();
        logic [9:0] seq [11];
        logic [3:0] prev [10];
        for (int i = 0; i < 10; i++) seq[i] = 10'h001 << i;
        seq[10] = 10'h100;
        for (int k = 0; k < 10; k++) prev[k] = lvl[k];
        for (int s = 0; s < 11; s++) begin
            for (int c = 0; c < 8; c++) begin
                pattern = seq[s];
                step();
                for (int k = 0; k < 10; k++) begin
                    checks++;
                    if (seq[s][k]) begin
                        if (lvl[k] !== 4'd15) begin
                            errors++;
                            $display("FAIL sweep_lead[%0d]: got %0d expected 15", k, lvl[k]);
                        end
                    end else if (lvl[k] > prev[k]) begin
                        errors++;
                        $display("FAIL sweep_tail[%0d]: got %0d expected <= %0d", k, lvl[k], prev[k]);
                    end
                    prev[k] = lvl[k];
                end
            end
        end
        pattern = 10'h000;
    endtask

    task automatic test_bypass();
        logic [9:0] vec [6];
        vec[0] = 10'h155; vec[1] = 10'h2AA; vec[2] = 10'h3FF;
        vec[3] = 10'h000; vec[4] = 10'h201; vec[5] = 10'h0F0;
        trail_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pattern = vec[i];
            step();
            checks++;
            if (led !== vec[i]) begin
                errors++;
                $display("FAIL bypass %0d: got %h expected %h", i, led, vec[i]);
            end
        end
        pattern = 10'h000;
        trail_en = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_fade();
        pattern = 10'h020;
        step();
        pattern = 10'h000;
        step();
        step();
        step();
        checks++;
        if (led[5] !== 1'b1) begin
            errors++;
            $display("FAIL midfade_lit: got %b expected 1", led[5]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (led !== 10'h000) begin
            errors++;
            $display("FAIL async_reset_led: got %h expected 000", led);
        end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (lvl[k] !== 4'd0) begin
                errors++;
                $display("FAIL async_reset_level[%0d]: got %0d expected 0", k, lvl[k]);
            end
        end
        step();
        step();
        rst = 1'b0;
        for (int n = 0; n < 30; n++) begin
            step();
            checks++;
            if (led !== 10'h000 || lvl[5] !== 4'd0) begin
                errors++;
                $display("FAIL no_resume n=%0d: led %h level %0d expected 000 0", n, led, lvl[5]);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        trail_en = 1'b1;
        pattern  = 10'h000;
        pattern2 = 10'h000;
        test_reset();
        test_set_fade();
        test_duty();
        test_collision();
        test_bounce_sweep();
        test_bypass();
        test_reset_mid_fade();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
